// File: rtl/pipeline_backend.sv
// rtl/pipeline_backend.sv - 4-phase instruction intake feeding a decode/execute/writeback pipeline
// over a 4 x 8-bit register file.
module pipeline_backend (
  input  logic       clk,
  input  logic       rst,
  input  logic       ipacket_req,
  output logic       ipacket_ack,
  input  logic [7:0] ipacket_pc,
  input  logic [7:0] ipacket_inst,
  output logic [7:0] debug_pin_r0,
  output logic [7:0] debug_pin_r1,
  output logic [7:0] debug_pin_r2,
  output logic [7:0] debug_pin_r3,
  output logic       debug_retire_valid,
  output logic [7:0] debug_retire_pc
);

  typedef enum logic {HS_IDLE, HS_ACKED} hs_state_t;

  hs_state_t  hs_state, hs_next;
  logic       accept;

  logic       dec_valid;
  logic [7:0] dec_pc;
  logic [7:0] dec_inst;

  logic       wb_valid;
  logic       wb_we;
  logic [1:0] wb_d;
  logic [7:0] wb_result;
  logic [7:0] wb_pc;

  logic [7:0] rf [4];

  logic [1:0] op, ra, rb, rd;
  logic [7:0] opnd_a, opnd_b, result;

  always_ff @(posedge clk) begin
    if (rst) hs_state <= HS_IDLE;
    else     hs_state <= hs_next;
  end

  always_comb begin
    hs_next = hs_state;
    accept  = 1'b0;
    case (hs_state)
      HS_IDLE: begin
        if (ipacket_req) begin
          accept  = 1'b1;
          hs_next = HS_ACKED;
        end
      end
      HS_ACKED: begin
        if (!ipacket_req) hs_next = HS_IDLE;
      end
      default: hs_next = HS_IDLE;
    endcase
  end

  assign ipacket_ack = (hs_state == HS_ACKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_pc    <= 8'h00;
      dec_inst  <= 8'h00;
    end else begin
      dec_valid <= accept;
      if (accept) begin
        dec_pc   <= ipacket_pc;
        dec_inst <= ipacket_inst;
      end
    end
  end

  assign op = dec_inst[7:6];
  assign ra = dec_inst[5:4];
  assign rb = dec_inst[3:2];
  assign rd = dec_inst[1:0];

  // The writeback register is committed on the same edge this read is captured,
  // so forward it to keep dependent instructions on the newest value.
  assign opnd_a = (wb_valid && wb_we && (wb_d == ra)) ? wb_result : rf[ra];
  assign opnd_b = (wb_valid && wb_we && (wb_d == rb)) ? wb_result : rf[rb];

  always_comb begin
    result = 8'h00;
    case (op)
      2'b01:   result = opnd_a + opnd_b;
      2'b10:   result = {4'b0000, dec_inst[5:2]};
      2'b11:   result = ~(opnd_a & opnd_b);
      default: result = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_d      <= 2'd0;
      wb_result <= 8'h00;
      wb_pc     <= 8'h00;
    end else begin
      wb_valid  <= dec_valid;
      wb_we     <= dec_valid && (op != 2'b00);
      wb_d      <= rd;
      wb_result <= result;
      wb_pc     <= dec_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      debug_retire_valid <= 1'b0;
      debug_retire_pc    <= 8'h00;
    end else begin
      debug_retire_valid <= wb_valid;
      if (wb_valid) begin
        debug_retire_pc <= wb_pc;
        if (wb_we) rf[wb_d] <= wb_result;
      end
    end
  end

  assign debug_pin_r0 = rf[0];
  assign debug_pin_r1 = rf[1];
  assign debug_pin_r2 = rf[2];
  assign debug_pin_r3 = rf[3];

endmodule

// File: tb/tb_pipeline_backend.sv
// tb/tb_pipeline_backend.sv - randomized bench for pipeline_backend against an
// in-order architectural model with a retire scoreboard.
module tb_pipeline_backend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ipacket_req = 1'b0;
  logic       ipacket_ack;
  logic [7:0] ipacket_pc = 8'h00;
  logic [7:0] ipacket_inst = 8'h00;
  logic [7:0] debug_pin_r0, debug_pin_r1, debug_pin_r2, debug_pin_r3;
  logic       debug_retire_valid;
  logic [7:0] debug_retire_pc;

  pipeline_backend dut (
    .clk                (clk),
    .rst                (rst),
    .ipacket_req        (ipacket_req),
    .ipacket_ack        (ipacket_ack),
    .ipacket_pc         (ipacket_pc),
    .ipacket_inst       (ipacket_inst),
    .debug_pin_r0       (debug_pin_r0),
    .debug_pin_r1       (debug_pin_r1),
    .debug_pin_r2       (debug_pin_r2),
    .debug_pin_r3       (debug_pin_r3),
    .debug_retire_valid (debug_retire_valid),
    .debug_retire_pc    (debug_retire_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    int          due;
    logic [31:0] regs;
  } retire_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          monitor_on = 1'b0;
  logic [7:0]  m [4];
  retire_t     exp_q [$];
  logic [7:0]  next_pc = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pins();
    return {debug_pin_r0, debug_pin_r1, debug_pin_r2, debug_pin_r3};
  endfunction

  function automatic logic [31:0] model_regs();
    return {m[0], m[1], m[2], m[3]};
  endfunction

  // Architectural execution in program order: read both operands, then write.
  task automatic model_exec(input logic [7:0] inst);
    int op, a, b, d, res;
    op = inst / 64;
    a  = (inst / 16) % 4;
    b  = (inst / 4) % 4;
    d  = inst % 4;
    case (op)
      1: res = (m[a] + m[b]) % 256;
      2: res = (inst / 4) % 16;
      3: res = 255 - (m[a] & m[b]);
      default: res = -1;
    endcase
    if (res >= 0) m[d] = res[7:0];
  endtask

  // Entered and left just after a falling edge.
  task automatic send(input logic [7:0] inst, input int hold, input int gap);
    retire_t e;
    ipacket_req  = 1'b1;
    ipacket_pc   = next_pc;
    ipacket_inst = inst;
    @(negedge clk);
    check("ack_after_accept", {31'b0, ipacket_ack}, 32'd1);
    model_exec(inst);
    e.pc   = next_pc;
    e.due  = cyc + 2;
    e.regs = model_regs();
    exp_q.push_back(e);
    next_pc = next_pc + 8'd1;
    ipacket_pc   = $urandom();
    ipacket_inst = $urandom();
    repeat (hold) begin
      @(negedge clk);
      check("ack_held", {31'b0, ipacket_ack}, 32'd1);
    end
    ipacket_req = 1'b0;
    @(negedge clk);
    check("ack_drop", {31'b0, ipacket_ack}, 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (monitor_on && !rst) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("retire_missing_pc", 32'hFFFF_FFFF, {24'b0, exp_q[0].pc});
        void'(exp_q.pop_front());
      end
      if (debug_retire_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_retire", 32'd1, 32'd0);
        end else begin
          retire_t e;
          e = exp_q.pop_front();
          check("retire_cycle", cyc, e.due);
          check("retire_pc", {24'b0, debug_retire_pc}, {24'b0, e.pc});
          check("regs_at_retire", pins(), e.regs);
        end
      end
    end
  end

  initial begin
    logic [7:0] dir [12];
    dir = '{8'h80, 8'h85, 8'h8A, 8'h8F, 8'h6C, 8'h48, 8'h62, 8'hE2, 8'h16, 8'h38, 8'hD5, 8'h58};
    for (int i = 0; i < 4; i++) m[i] = 8'h00;

    ipacket_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_regs", pins(), 32'h0);
    check("rst_ack", {31'b0, ipacket_ack}, 32'd0);
    check("rst_retire_valid", {31'b0, debug_retire_valid}, 32'd0);
    check("rst_retire_pc", {24'b0, debug_retire_pc}, 32'd0);
    ipacket_req = 1'b0;
    rst = 1'b0;
    monitor_on = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) send(dir[i], 0, 0);
    repeat (4) @(negedge clk);
    check("directed_final_regs", pins(), 32'hFCFE_FE03);

    send(8'h8E, 10, 1);

    // A req pulse that never spans a rising edge must not be accepted.
    ipacket_req = 1'b1;
    #2 ipacket_req = 1'b0;
    @(negedge clk);
    check("glitch_no_ack", {31'b0, ipacket_ack}, 32'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 60; i++)
      send($urandom(), $urandom_range(0, 3), $urandom_range(0, 2));
    repeat (4) @(negedge clk);

    ipacket_req  = 1'b1;
    ipacket_pc   = 8'hAA;
    ipacket_inst = 8'hBD;
    @(negedge clk);
    check("rst_test_accept", {31'b0, ipacket_ack}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    ipacket_req = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("midrst_retire_valid", {31'b0, debug_retire_valid}, 32'd0);
    end
    check("midrst_regs", pins(), 32'h0);
    check("midrst_ack", {31'b0, ipacket_ack}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_retire_q", exp_q.size(), 32'd0);
    send(8'h9D, 0, 0);
    send(8'h74, 1, 0);
    repeat (4) @(negedge clk);
    check("post_rst_regs", pins(), model_regs());
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_backend.md
PIPELINE_BACKEND -- requirements
Module: pipeline_backend

Interface
REQ-001 No parameters; data width fixed at 8 bits, 4 registers R0..R3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 ipacket_req  input  1  instruction packet request, 4-phase handshake.
REQ-005 ipacket_ack  output  1  instruction packet acknowledge.
REQ-006 ipacket_pc  input  8  PC of offered instruction; valid while req=1.
REQ-007 ipacket_inst  input  8  offered instruction; valid while req=1.
REQ-008 debug_pin_r0..debug_pin_r3  output  8 each  architectural register contents.
REQ-009 debug_retire_valid  output  1  one-cycle pulse when an instruction retires.
REQ-010 debug_retire_pc  output  8  PC of the retiring instruction; holds its last value otherwise.

Function
REQ-011 Encoding SHALL be op=inst[7:6], a=inst[5:4], b=inst[3:2], d=inst[1:0].
REQ-012 op 00 NOP: no register write; retires normally.
REQ-013 op 01 ADD: Rd = Ra + Rb mod 256; carry discarded.
REQ-014 op 10 SET: Rd = zero-extended inst[5:2] (range 0..15).
REQ-015 op 11 NAND: Rd = ~(Ra & Rb).
REQ-016 Handshake: instruction accepted at an edge where req=1 and ack=0; pc and inst captured into decode register; ack=1 after that edge.
REQ-017 ack SHALL stay 1 until req=0 is sampled; ack=0 after that edge; no new accept until after ack returns to 0.
REQ-018 Exactly one instruction accepted per req/ack 4-phase cycle.
REQ-019 Pipeline: accept edge T (decode reg loaded) -> edge T+1 operands read and result computed into writeback reg -> edge T+2 register file written, debug pins updated, retire_valid=1 for one cycle.
REQ-020 Operand read SHALL bypass the pending writeback result when its destination matches Ra or Rb, so back-to-back dependent instructions see the newest value.
REQ-021 Register file write and operand read of same register in same cycle: reader gets the new value.
REQ-022 Ra and Rb may be equal, and either may equal Rd; semantics are read-before-write.
REQ-023 Pipeline advances unconditionally (no stall); empty slots carry valid=0 and cause no write and no retire pulse.
REQ-024 req deasserted before ack rises: the pending accept is abandoned; no instruction accepted.

Reset
REQ-025 While rst=1: R0..R3=0x00, ipacket_ack=0, all pipeline valid bits 0, debug_retire_valid=0, debug_retire_pc=0x00.
REQ-026 rst asserted mid-handshake or mid-pipeline SHALL discard in-flight instructions; after release, ack=0 and the first edge with req=1 accepts a new instruction.

Verification
REQ-027 After reset, issue SET 0x80,0x85,0x8A,0x8F -> R0=0,R1=1,R2=2,R3=3.
REQ-028 Continue with ADD 0x6C, ADD 0x48, ADD 0x62 -> R0=5, then R0=7, then R2=9; result holds under the fastest legal handshake timing (bypass).
REQ-029 NAND 0xE2 -> R2=0xFE; NOPs 0x16,0x38 -> no register change, retire pulses with pc.
REQ-030 NAND 0xD5 -> R1=0xFE; ADD 0x58 -> R0=0xFC (0xFE+0xFE wraps).
REQ-031 Handshake check: req held high 10 cycles -> exactly one accept, ack stays 1 until req drops, then ack=0 one edge later.
REQ-032 Assert rst one cycle after an accept -> no retire, all registers 0x00, ack=0; next handshake after reset proceeds normally.
